multicycle_adder: RTL and testbench

Parametrised multi-cycle binary adder. It adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, using a registered carry chain. Operands are accepted and results are returned over valid/ready handshakes. It is the sequential, width-generic successor to the single-bit half/full adder cells, and is the arithmetic building block for the larger datapath blocks in the FA library.

---
 rtl/adder_pkg.sv | 23 ++
 rtl/digit_adder.sv | 33 +++
 rtl/full_adder.sv | 15 +
 rtl/multicycle_adder.sv | 139 +++++++++++++
 tb/tb_multicycle_adder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle adder family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to count to value-1, never less than one so that a
    // single-step configuration still has a real counter register.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple adder built from full_adder cells; also exposes the carry into its top bit.
// Latency: combinational.
// Backpressure: none.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < DIGIT; g++) begin : g_fa
        full_adder u_fa (
            .i_a    (i_a[g]),
            .i_b    (i_b[g]),
            .i_cin  (w_c[g]),
            .o_sum  (o_sum[g]),
            .o_cout (w_c[g+1])
        );
    end

    assign o_cout  = w_c[DIGIT];
    // Carry entering the top bit; XOR with o_cout gives signed overflow.
    assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/multicycle_adder.sv
// Width-generic adder computing A+B+cin DIGIT bits per cycle through a registered carry.
// Latency: STEPS=WIDTH/DIGIT cycles from operand acceptance to o_valid.
// Backpressure: result and o_valid held in DONE until i_ready; o_ready only while IDLE.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int STEPS = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW    = clog2_min1(STEPS);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("multicycle_adder: WIDTH must be >= 1 and a multiple of DIGIT, with 1 <= DIGIT <= WIDTH");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             r_carry;
    logic             r_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_dsum;
    logic             w_dcout;
    logic             w_dcmsb;

    assign w_accept = (r_state == S_IDLE) && i_valid;
    assign w_last   = (r_cnt == CW'(STEPS - 1));

    // Operands are shifted right each step, so the current digit is always the low slice.
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a     (r_a[DIGIT-1:0]),
        .i_b     (r_b[DIGIT-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_dsum),
        .o_cout  (w_dcout),
        .o_c_msb (w_dcmsb)
    );

    // Next-state decode: accept in IDLE, step through digits in ADD, wait for consumer in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_state_nxt = S_ADD;
            S_ADD:   if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // New digit enters at the top while older digits shift down; after STEPS shifts
    // digit 0 has reached the bottom and the word is assembled in place.
    always_comb begin
        w_acc_nxt = r_acc >> DIGIT;
        w_acc_nxt[WIDTH-1 -: DIGIT] = w_dsum;
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake flags registered from the next state so they track it without a comb path.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == S_IDLE);
            r_valid <= (w_state_nxt == S_DONE);
        end
    end

    // Datapath: capture operands on accept, then one digit per ADD cycle; results publish on the last digit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
        end else if (r_state == S_ADD) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_acc   <= w_acc_nxt;
            r_carry <= w_dcout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_acc_nxt;
                r_cout <= w_dcout;
                r_ovf  <= w_dcmsb ^ w_dcout;
            end
        end
    end

    assign o_ready    = r_ready;
    assign o_valid    = r_valid;
    assign o_sum      = r_sum;
    assign o_carry    = r_cout;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder in three configurations (8/4, 8/1, 4/2).
// Latency: checked against STEPS per configuration.
// Backpressure: exercised by holding i_ready low on the 8/4 instance.
module tb_multicycle_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8, DIGIT=4
    logic       m_valid, m_ready, m_cin, m_ovalid, m_iready, m_carry, m_ovf;
    logic [7:0] m_a, m_b, m_sum;
    // WIDTH=8, DIGIT=1
    logic       s_valid, s_ready, s_cin, s_ovalid, s_iready, s_carry, s_ovf;
    logic [7:0] s_a, s_b, s_sum;
    // WIDTH=4, DIGIT=2
    logic       e_valid, e_ready, e_cin, e_ovalid, e_iready, e_carry, e_ovf;
    logic [3:0] e_a, e_b, e_sum;

    multicycle_adder #(.WIDTH(8), .DIGIT(4)) u_dut_m (
        .i_clk(clk), .i_rst(rst), .i_valid(m_valid), .o_ready(m_ready),
        .i_a(m_a), .i_b(m_b), .i_cin(m_cin), .o_valid(m_ovalid), .i_ready(m_iready),
        .o_sum(m_sum), .o_carry(m_carry), .o_overflow(m_ovf)
    );

    multicycle_adder #(.WIDTH(8), .DIGIT(1)) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_ready),
        .i_a(s_a), .i_b(s_b), .i_cin(s_cin), .o_valid(s_ovalid), .i_ready(s_iready),
        .o_sum(s_sum), .o_carry(s_carry), .o_overflow(s_ovf)
    );

    multicycle_adder #(.WIDTH(4), .DIGIT(2)) u_dut_e (
        .i_clk(clk), .i_rst(rst), .i_valid(e_valid), .o_ready(e_ready),
        .i_a(e_a), .i_b(e_b), .i_cin(e_cin), .o_valid(e_ovalid), .i_ready(e_iready),
        .o_sum(e_sum), .o_carry(e_carry), .o_overflow(e_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 8/4 instance, including the output handshake.
    task automatic m_run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec, input logic ev);
        int lat;
        m_a = a; m_b = b; m_cin = cin; m_valid = 1'b1;
        check({tag, ".ready"}, m_ready, 1);
        step();
        m_valid = 1'b0;
        lat = 0;
        while (!m_ovalid && lat < 50) begin
            step();
            lat++;
        end
        check({tag, ".lat"}, lat, 2);
        check({tag, ".sum"}, m_sum, es);
        check({tag, ".carry"}, m_carry, ec);
        check({tag, ".ovf"}, m_ovf, ev);
        m_iready = 1'b1;
        step();
        m_iready = 1'b0;
        check({tag, ".vld_rdy_after"}, {m_ovalid, m_ready}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int lat;
        int hits;
        int t_first;
        int t_last;
        logic       rdy0;
        logic [4:0] s;
        logic       ev;
        logic [31:0] got;
        logic [31:0] exp;

        {m_valid, m_cin, m_iready, m_a, m_b} = '0;
        {s_valid, s_cin, s_iready, s_a, s_b} = '0;
        {e_valid, e_cin, e_iready, e_a, e_b} = '0;

        // Reset state
        #12;
        check("reset.m_ready", m_ready, 1);
        check("reset.m_valid", m_ovalid, 0);
        check("reset.m_result", {m_sum, m_carry, m_ovf}, 0);
        check("reset.e_ready", e_ready, 1);
        rst = 1'b0;
        step();

        // Basic vectors
        m_run("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        m_run("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        m_run("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        m_run("12_34c", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

        // Backpressure with stray requests during ADD/DONE
        m_a = 8'h21; m_b = 8'h43; m_cin = 1'b0; m_valid = 1'b1;
        step();
        m_a = 8'hFF; m_b = 8'hFF; m_cin = 1'b1;
        lat = 0;
        while (!m_ovalid && lat < 50) begin
            step();
            lat++;
        end
        check("bp.lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            check("bp.hold", {m_ovalid, m_ready, m_sum, m_carry, m_ovf}, {1'b1, 1'b0, 8'h64, 1'b0, 1'b0});
            step();
        end
        m_valid = 1'b0;
        m_iready = 1'b1;
        step();
        m_iready = 1'b0;
        check("bp.release", {m_ovalid, m_ready}, 2'b01);
        check("bp.sum_kept", m_sum, 8'h64);

        // Asynchronous reset in the middle of ADD
        m_a = 8'h33; m_b = 8'h44; m_valid = 1'b1;
        step();
        m_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst.vld_rdy", {m_ovalid, m_ready}, 2'b01);
        check("arst.sum", m_sum, 0);
        #1 rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m_ovalid) hits++;
        end
        check("arst.no_valid", hits, 0);
        m_run("05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

        // Bit-serial configuration
        s_a = 8'hAA; s_b = 8'h55; s_cin = 1'b1; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        lat = 0;
        while (!s_ovalid && lat < 50) begin
            step();
            lat++;
        end
        check("ser.lat", lat, 8);
        check("ser.result", {s_sum, s_carry, s_ovf}, {8'h00, 1'b1, 1'b0});
        s_iready = 1'b1;
        step();
        s_iready = 1'b0;
        check("ser.ready_after", s_ready, 1);

        // Exhaustive back-to-back sweep on the 4/2 instance
        e_iready = 1'b1;
        e_valid  = 1'b1;
        t_first  = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    e_a = a[3:0]; e_b = b[3:0]; e_cin = c[0];
                    s  = 5'(a + b + c);
                    ev = (a[3] == b[3]) && (s[3] != a[3]);
                    rdy0 = e_ready;
                    step();
                    if (a == 0 && b == 0 && c == 0) t_first = cyc;
                    lat = 0;
                    while (!e_ovalid && lat < 20) begin
                        step();
                        lat++;
                    end
                    got = {21'b0, rdy0, lat[3:0], e_ovf, e_carry, e_sum};
                    exp = {21'b0, 1'b1, 4'd2, ev, s[4], s[3:0]};
                    check($sformatf("sweep.%0h+%0h+%0d", a, b, c), got, exp);
                    step();
                end
            end
        end
        t_last = cyc;
        e_valid = 1'b0;
        check("sweep.total_cycles", t_last - t_first, 511 * 4 + 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
